// File: rtl/i2c_cmd_arbiter_if.sv
// Byte-level I2C command channel: a one-cycle req with cmd/wr_data, answered
// later by a one-cycle done carrying rd_data.
interface i2c_cmd_arbiter_if;
    logic       req;
    logic [3:0] cmd;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       done;
    logic       busy;

    // busy exists only on the arbiter's master-facing ports; the controller has none
    modport master (output req, cmd, wr_data, input rd_data, done);
    modport slave  (input req, cmd, wr_data, output rd_data, done, busy);
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin, transaction-locked sharing of one byte-level I2C controller
// between two masters, with per-byte timeout and request-overflow flags.
module i2c_cmd_arbiter #(
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [3:0] STOP_MASK   = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_cmd_arbiter_if.slave  m0,
    i2c_cmd_arbiter_if.slave  m1,
    i2c_cmd_arbiter_if.master ctl,
    output logic [1:0]        owner,
    output logic              err_timeout,
    output logic [1:0]        err_ovf
);
    localparam int            CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMAX = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      vld_q, vld_d;
    logic [1:0][3:0] scmd_q, scmd_d;
    logic [1:0][7:0] swd_q, swd_d;
    logic [1:0]      mdone_q, mdone_d;
    logic [1:0][7:0] mrd_q, mrd_d;
    logic            req_q, req_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [7:0]      wd_q, wd_d;
    logic            sel_q, sel_d;
    logic            lg_q, lg_d;
    logic [1:0]      owner_q, owner_d;
    logic            to_q, to_d;
    logic [1:0]      ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [1:0]      mreq;
    logic [1:0][3:0] mcmd;
    logic [1:0][7:0] mwd;
    logic [1:0]      elig;
    logic            pick;
    logic            tmo_hit;

    assign mreq = {m1.req, m0.req};
    assign mcmd = {m1.cmd, m0.cmd};
    assign mwd  = {m1.wr_data, m0.wr_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= '0;
            scmd_q  <= '0;
            swd_q   <= '0;
            mdone_q <= '0;
            mrd_q   <= '0;
            req_q   <= 1'b0;
            cmd_q   <= '0;
            wd_q    <= '0;
            sel_q   <= 1'b0;
            lg_q    <= 1'b1;
            owner_q <= '0;
            to_q    <= 1'b0;
            ovf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            scmd_q  <= scmd_d;
            swd_q   <= swd_d;
            mdone_q <= mdone_d;
            mrd_q   <= mrd_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            wd_q    <= wd_d;
            sel_q   <= sel_d;
            lg_q    <= lg_d;
            owner_q <= owner_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        scmd_d  = scmd_q;
        swd_d   = swd_q;
        mdone_d = '0;
        mrd_d   = mrd_q;
        req_d   = 1'b0;
        cmd_d   = cmd_q;
        wd_d    = wd_q;
        sel_d   = sel_q;
        lg_d    = lg_q;
        owner_d = owner_q;
        to_d    = 1'b0;
        ovf_d   = '0;
        cnt_d   = cnt_q;

        // A slot freed at the previous edge reads empty here, so a req in the
        // done cycle is accepted; a req against a full slot is dropped.
        for (int i = 0; i < 2; i++) begin
            if (mreq[i]) begin
                if (vld_q[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    vld_d[i]  = 1'b1;
                    scmd_d[i] = mcmd[i];
                    swd_d[i]  = mwd[i];
                end
            end
        end

        elig    = (owner_q != 2'b00) ? (vld_q & owner_q) : vld_q;
        pick    = (elig == 2'b11) ? ~lg_q : elig[1];
        tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == TMAX);

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    req_d   = 1'b1;
                    cmd_d   = scmd_q[pick];
                    wd_d    = swd_q[pick];
                    sel_d   = pick;
                    lg_d    = pick;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // done beats a timeout landing on the same cycle
                if (ctl.done) begin
                    mdone_d[sel_q] = 1'b1;
                    mrd_d[sel_q]   = ctl.rd_data;
                    vld_d[sel_q]   = 1'b0;
                    owner_d        = (|(cmd_q & STOP_MASK)) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
                    state_d        = IDLE;
                end else if (tmo_hit) begin
                    mdone_d[sel_q] = 1'b1;
                    mrd_d[sel_q]   = 8'h00;
                    vld_d[sel_q]   = 1'b0;
                    to_d           = 1'b1;
                    owner_d        = 2'b00;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0.busy     = vld_q[0];
    assign m0.done     = mdone_q[0];
    assign m0.rd_data  = mrd_q[0];
    assign m1.busy     = vld_q[1];
    assign m1.done     = mdone_q[1];
    assign m1.rd_data  = mrd_q[1];
    assign ctl.req     = req_q;
    assign ctl.cmd     = cmd_q;
    assign ctl.wr_data = wd_q;
    assign owner       = owner_q;
    assign err_timeout = to_q;
    assign err_ovf     = ovf_q;
endmodule
